// File: rtl/priority_enc.sv
// rtl/priority_enc.sv - registered lowest-index-first priority encoder
// Optional PRIORITY_ENC_HOLD_EN: Y holds its last value when no request is present.
module priority_enc #(
  parameter  int N  = 4,
  localparam int YW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  D,
  output logic [YW-1:0] Y,
  output logic          valid
);

  logic [YW-1:0] enc;
  logic          any;

  // Scan from the lowest-priority bit upward so the lowest set index wins last.
  always_comb begin
    enc = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (D[i]) begin
        enc = YW'(N - 1 - i);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= any;
`ifdef PRIORITY_ENC_HOLD_EN
      if (any) begin
        Y <= enc;
      end
`else
      Y <= enc;
`endif
    end
  end

endmodule

// File: tb/tb_priority_enc.sv
// tb/tb_priority_enc.sv - directed and random scoreboard bench for priority_enc
// Honours PRIORITY_ENC_HOLD_EN in its reference model.
module tb_priority_enc;

  typedef struct packed {
    logic [1:0] y;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] D   = 4'b0000;
  logic [1:0] Y;
  logic       valid;

  exp_t       sb[$];
  logic [1:0] model_y = 2'd0;
  int         passed  = 0;
  int         total   = 0;

  priority_enc #(.N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .D     (D),
    .Y     (Y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] ref_y(logic [3:0] d, logic [1:0] prev);
    if (d[0])      return 2'd3;
    else if (d[1]) return 2'd2;
    else if (d[2]) return 2'd1;
    else if (d[3]) return 2'd0;
`ifdef PRIORITY_ENC_HOLD_EN
    return prev;
`else
    return 2'd0;
`endif
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive D away from the edge, push the expected result, then compare after the edge.
  task automatic apply(logic [3:0] d);
    exp_t e;
    @(negedge clk);
    D       = d;
    model_y = ref_y(d, model_y);
    e.y     = model_y;
    e.v     = |d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 4'd1, 4'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("y d=%b", d), {2'b00, Y}, {2'b00, e.y});
      chk($sformatf("valid d=%b", d), {3'b000, valid}, {3'b000, e.v});
    end
  endtask

  initial begin
    logic [3:0] dirs[10];
    dirs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
             4'b1100, 4'b1010, 4'b1110, 4'b1111, 4'b0111, 4'b0011};

    // Reset state
    @(posedge clk);
    #1;
    chk("reset_y", {2'b00, Y}, 4'd0);
    chk("reset_valid", {3'b000, valid}, 4'd0);
    @(negedge clk);
    rst     = 1'b0;
    model_y = 2'd0;

    foreach (dirs[i]) apply(dirs[i]);

    // Empty input, and hold behaviour after a 0100 request
    apply(4'b0000);
    apply(4'b0100);
    apply(4'b0000);

    // Latency: a change just after the edge must not show until the next edge
    apply(4'b1000);
    D = 4'b0001;
    #3;
    chk("latency_hold_y", {2'b00, Y}, 4'd0);
    chk("latency_hold_valid", {3'b000, valid}, 4'd1);
    @(posedge clk);
    #1;
    chk("latency_next_y", {2'b00, Y}, 4'd3);
    model_y = 2'd3;

    // Asynchronous reset mid-run
    apply(4'b1111);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_y", {2'b00, Y}, 4'd0);
    chk("async_rst_valid", {3'b000, valid}, 4'd0);
    @(posedge clk);
    #1;
    chk("rst_held_y", {2'b00, Y}, 4'd0);
    chk("rst_held_valid", {3'b000, valid}, 4'd0);
    @(negedge clk);
    rst     = 1'b0;
    model_y = 2'd0;
    sb.delete();

    apply(4'b0110);

    for (int k = 0; k < 1000; k++) begin
      apply(4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
